// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer feeding the HI/LO pair.
//
// It accepts MULT/MULTU/DIV/DIVU from the execute stage. A multiply runs for a
// fixed MUL_LAT cycles. A divide is a 32-step radix-2 restoring divide. Either
// operation ends in a one-cycle writeback that strobes HI and LO together.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_op               0=MULT 1=MULTU 2=DIV 3=DIVU
//   req_a, req_b         rs / rt operands
//   flush                cancels the operation in flight, gates the writeback
//   busy                 high whenever not IDLE
//   hi_write, lo_write   one-cycle write strobes
//   hi_data, lo_data     product[63:32]/[31:0] or remainder/quotient
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; req_ready high
// MUL   | multiply in progress, MUL_LAT cycles
// DIV   | restoring divide, one quotient bit per cycle, MSB first
// WB    | HI/LO strobes high for one cycle unless flushed
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvs;
  logic [31:0] r_hi_hold;
  logic [31:0] r_lo_hold;

  logic        w_accept;
  logic        w_req_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_sa;
  logic [63:0] w_sb;
  logic [63:0] w_ua;
  logic [63:0] w_ub;
  logic [63:0] w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic        w_op_signed;
  logic [31:0] w_wb_hi;
  logic [31:0] w_wb_lo;
  logic        w_wb_write;

  assign w_accept     = req_valid && req_ready && !flush;
  // op bit 0 set means the unsigned variant (MULTU / DIVU)
  assign w_req_signed = !req_op[0];
  assign w_a_mag      = (w_req_signed && req_a[31]) ? (~req_a + 32'd1) : req_a;
  assign w_b_mag      = (w_req_signed && req_b[31]) ? (~req_b + 32'd1) : req_b;

  // Product from the latched operands; the low 64 bits of a 64x64 product of
  // sign- or zero-extended operands give the signed or unsigned result.
  assign w_sa   = {{32{r_a[31]}}, r_a};
  assign w_sb   = {{32{r_b[31]}}, r_b};
  assign w_ua   = {32'd0, r_a};
  assign w_ub   = {32'd0, r_b};
  assign w_prod = r_op[0] ? (w_ua * w_ub) : (w_sa * w_sb);

  // Restoring step: shift the next dividend bit into the 33-bit partial
  // remainder and subtract the divisor when it fits.
  assign w_shift    = {r_rem, r_quo[31]};
  assign w_ge       = w_shift >= {1'b0, r_dvs};
  assign w_rem_next = w_ge ? 32'(w_shift - {1'b0, r_dvs}) : w_shift[31:0];

  // Sign fixup and divide-by-zero are resolved combinationally in WB.
  assign w_op_signed = !r_op[0];
  always_comb begin
    w_wb_hi = r_prod[63:32];
    w_wb_lo = r_prod[31:0];
    if (r_op[1]) begin
      if (r_b == 32'd0) begin
        w_wb_hi = r_a;
        w_wb_lo = 32'hFFFF_FFFF;
      end else begin
        w_wb_lo = (w_op_signed && (r_a[31] ^ r_b[31])) ? (~r_quo + 32'd1) : r_quo;
        w_wb_hi = (w_op_signed && r_a[31]) ? (~r_rem + 32'd1) : r_rem;
      end
    end
  end

  assign w_wb_write = (r_state == WB) && !flush;
  assign hi_write   = w_wb_write;
  assign lo_write   = w_wb_write;
  assign hi_data    = (r_state == WB) ? w_wb_hi : r_hi_hold;
  assign lo_data    = (r_state == WB) ? w_wb_lo : r_lo_hold;
  assign req_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_op      <= 2'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_cnt     <= 5'd0;
      r_prod    <= 64'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_dvs     <= 32'd0;
      r_hi_hold <= 32'd0;
      r_lo_hold <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= req_op;
            r_a   <= req_a;
            r_b   <= req_b;
            r_rem <= 32'd0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
            if (req_op[1]) begin
              r_cnt   <= 5'd31;
              r_state <= DIV;
            end else begin
              r_cnt   <= 5'(MUL_LAT - 1);
              r_state <= MUL;
            end
          end
        end
        MUL: begin
          r_prod <= w_prod;
          if (flush) begin
            r_state <= IDLE;
          end else if (r_cnt == 5'd0) begin
            r_state <= WB;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[30:0], w_ge};
          if (flush) begin
            r_state <= IDLE;
          end else if (r_cnt == 5'd0) begin
            r_state <= WB;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        WB: begin
          if (w_wb_write) begin
            r_hi_hold <= w_wb_hi;
            r_lo_hold <= w_wb_lo;
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_ctrl #(.MUL_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
    .hi_write(hi_write), .lo_write(lo_write), .hi_data(hi_data), .lo_data(lo_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready: got %b want 1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  // Watch cycles 1..max, recording the writeback cycle and its data.
  task automatic observe(input int max, output int wb_cyc, output int nstr,
                         output logic [31:0] h, output logic [31:0] l,
                         output logic [63:0] bh, output logic [63:0] rh);
    wb_cyc = 0; nstr = 0; h = 32'd0; l = 32'd0; bh = 64'd0; rh = 64'd0;
    for (int i = 1; i <= max; i++) begin
      bh[i] = busy;
      rh[i] = req_ready;
      if (hi_write || lo_write) begin
        nstr++;
        if (wb_cyc == 0) begin
          wb_cyc = i; h = hi_data; l = lo_data;
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_a = 32'd0; req_b = 32'd0; flush = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if ({hi_write, lo_write} !== 2'b00) begin n_bad++; $display("FAIL rst_strobe: got %b want 00", {hi_write, lo_write}); end
    n_cmp++; if ({hi_data, lo_data} !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {hi_data, lo_data}); end
    repeat (2) step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_mul();
    int wb, ns;
    logic [31:0] h, l;
    logic [63:0] bh, rh;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    observe(6, wb, ns, h, l, bh, rh);
    n_cmp++; if (wb != 2) begin n_bad++; $display("FAIL multu_wb_cycle: got %0d want 2", wb); end
    n_cmp++; if (h !== 32'hFFFF_FFFE || l !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_data: got %h_%h want fffffffe_00000001", h, l); end
    n_cmp++; if (rh[3] !== 1'b1) begin n_bad++; $display("FAIL multu_ready_c3: got %b want 1", rh[3]); end
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    observe(6, wb, ns, h, l, bh, rh);
    n_cmp++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFA) begin n_bad++; $display("FAIL mult_data: got %h_%h want ffffffff_fffffffa", h, l); end
    n_cmp++; if (ns != 1) begin n_bad++; $display("FAIL mult_strobes: got %0d want 1", ns); end
    n_cmp++; if (bh[3:1] !== 3'b011) begin n_bad++; $display("FAIL mult_busy_c1_3: got %b want 011", bh[3:1]); end
  endtask

  task automatic test_div();
    logic [1:0]  ops [7] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [31:0] as  [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
    logic [31:0] bs  [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'h10, 32'd0};
    logic [31:0] ehs [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0, 32'hF, 32'hFFFF_FFF0};
    logic [31:0] els [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0FFF_FFFF, 32'hFFFF_FFFF};
    int wb, ns;
    logic [31:0] h, l;
    logic [63:0] bh, rh;
    for (int k = 0; k < 7; k++) begin
      issue(ops[k], as[k], bs[k]);
      observe(36, wb, ns, h, l, bh, rh);
      n_cmp++; if (wb != 33) begin n_bad++; $display("FAIL div%0d_wb_cycle: got %0d want 33", k, wb); end
      n_cmp++; if (h !== ehs[k] || l !== els[k]) begin n_bad++; $display("FAIL div%0d_data: got hi=%h lo=%h want hi=%h lo=%h", k, h, l, ehs[k], els[k]); end
      n_cmp++; if (ns != 1 || rh[34] !== 1'b1) begin n_bad++; $display("FAIL div%0d_strobe_ready: got %0d/%b want 1/1", k, ns, rh[34]); end
    end
  endtask

  task automatic test_flush();
    int wb, ns;
    logic [31:0] h, l;
    logic [63:0] bh, rh;
    issue(2'd3, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_div_idle: got busy=%b ready=%b want 0/1", busy, req_ready); end
    observe(30, wb, ns, h, l, bh, rh);
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL flush_div_nostrobe: got %0d want 0", ns); end
    issue(2'd1, 32'd7, 32'd7);
    step();
    n_cmp++; if (hi_write !== 1'b1) begin n_bad++; $display("FAIL flush_wb_reached: got %b want 1", hi_write); end
    flush = 1'b1;
    #1;
    n_cmp++; if ({hi_write, lo_write} !== 2'b00) begin n_bad++; $display("FAIL flush_wb_gated: got %b want 00", {hi_write, lo_write}); end
    step();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_wb_idle: got %b want 0", busy); end
    req_valid = 1'b1; req_op = 2'd1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_reject: got busy=%b want 0", busy); end
    issue(2'd1, 32'd3, 32'd4);
    observe(5, wb, ns, h, l, bh, rh);
    n_cmp++; if (h !== 32'd0 || l !== 32'd12 || wb != 2) begin n_bad++; $display("FAIL after_flush_multu: got hi=%h lo=%h c%0d want 0/c/c2", h, l, wb); end
  endtask

  task automatic test_back_to_back();
    int wb, ns;
    logic [31:0] h, l;
    logic [63:0] bh, rh;
    issue(2'd3, 32'd12345, 32'd17);
    repeat (19) step();
    resetn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_state: got busy=%b ready=%b want 0/1", busy, req_ready); end
    n_cmp++; if ({hi_write, lo_write} !== 2'b00 || lo_data !== 32'd0 || hi_data !== 32'd0) begin n_bad++; $display("FAIL midrst_outputs: got %b %h %h want 00 0 0", {hi_write, lo_write}, hi_data, lo_data); end
    #2;
    resetn = 1'b1;
    step();
    observe(20, wb, ns, h, l, bh, rh);
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL midrst_nostrobe: got %0d want 0", ns); end
    issue(2'd1, 32'd2, 32'd3);
    req_valid = 1'b1; req_op = 2'd1; req_a = 32'd5; req_b = 32'd5;
    step();
    n_cmp++; if (lo_write !== 1'b1 || lo_data !== 32'd6 || req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first: got w=%b lo=%h rdy=%b want 1/6/0", lo_write, lo_data, req_ready); end
    step();
    n_cmp++; if (req_ready !== 1'b1 || lo_write !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_c3: got rdy=%b w=%b want 1/0", req_ready, lo_write); end
    step();
    req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || hi_write !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_c4: got busy=%b w=%b want 1/0", busy, hi_write); end
    step();
    n_cmp++; if (lo_write !== 1'b1 || lo_data !== 32'd25 || hi_data !== 32'd0) begin n_bad++; $display("FAIL b2b_second: got w=%b hi=%h lo=%h want 1/0/19", lo_write, hi_data, lo_data); end
    step();
    n_cmp++; if (lo_write !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got w=%b busy=%b want 0/0", lo_write, busy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
